// File: rtl/repack_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : repack_wr_sched
// Purpose  : Write scheduler between the pixel repacker word stream and the
//            frame-buffer write port. Buffers incoming words in a 2*BURST
//            FIFO and emits fixed-length write bursts (one command, then the
//            data beats) at linearly increasing byte addresses inside one
//            frame region. Wraps to BASE at frame end and pulses frame_done_o.
//
// Ports    : clk_i, rst_ni           clock / asynchronous active-low reset
//            in_val_i, in_data_i,    repacked word input (valid/ready)
//            in_rdy_o
//            cmd_val_o, cmd_addr_o,  burst command (start byte address,
//            cmd_len_o, cmd_rdy_i    beats minus one)
//            wr_val_o, wr_data_o,    write beats; wr_last_o marks the final
//            wr_last_o, wr_rdy_i     beat of each burst
//            frame_done_o            one-cycle pulse after a frame completes
//            flush_i                 drain a partial burst (SCHED_FLUSH_EN)
//
// Build    : define SCHED_FLUSH_EN to add flush_i and partial-burst draining.
//
// Revision : 1.0  initial release
// ============================================================================
module repack_wr_sched #(
  parameter int            W           = 64,
  parameter int            BURST       = 16,
  parameter int            AW          = 32,
  parameter logic [AW-1:0] BASE        = '0,
  parameter int            FRAME_WORDS = 1920*1080*3/8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_val_i,
  input  logic [W-1:0]  in_data_i,
  output logic          in_rdy_o,
  output logic          cmd_val_o,
  output logic [AW-1:0] cmd_addr_o,
  output logic [7:0]    cmd_len_o,
  input  logic          cmd_rdy_i,
  output logic          wr_val_o,
  output logic [W-1:0]  wr_data_o,
  output logic          wr_last_o,
  input  logic          wr_rdy_i,
  output logic          frame_done_o
`ifdef SCHED_FLUSH_EN
  ,
  input  logic          flush_i
`endif
);

  // --------------------------------------------------------------------------
  // Derived sizes and constants
  // --------------------------------------------------------------------------
  localparam int DEPTH = 2 * BURST;             // FIFO depth, power of two
  localparam int PW    = $clog2(DEPTH);         // FIFO pointer width
  localparam int CW    = $clog2(DEPTH + 1);     // occupancy 0..DEPTH
  localparam int WCW   = $clog2(FRAME_WORDS + 1);
  localparam int WSW   = WCW + 1;               // word-counter sum, no overflow

  localparam logic [CW-1:0]  c_full     = CW'(DEPTH);
  localparam logic [CW-1:0]  c_burst    = CW'(BURST);
  localparam logic [7:0]     c_len_full = 8'(BURST - 1);
  localparam logic [WSW-1:0] c_frame    = WSW'(FRAME_WORDS);
  localparam logic [AW-1:0]  c_bytes    = AW'(W / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_rdy_o  = (count_q < c_full);
  assign push      = in_val_i && in_rdy_o;
  assign pop       = wr_val_o && wr_rdy_i;
  assign wr_data_o = mem_q[rptr_q];

  // Storage carries no reset: contents are only observed through count_q,
  // which is cleared on reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= in_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional flush request
  // --------------------------------------------------------------------------
  logic flush_req;
`ifdef SCHED_FLUSH_EN
  assign flush_req = flush_i;
`else
  assign flush_req = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Burst scheduler
  // --------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     beat_q, beat_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           done_q, done_d;

  logic [8:0]     burst_words;
  logic [AW-1:0]  addr_inc;
  logic [WSW-1:0] wcnt_sum;
  logic           frame_end;

  // Words in the current burst; 9 bits so a 256-beat burst is representable.
  assign burst_words = {1'b0, len_q} + 9'd1;
  assign addr_inc    = AW'(burst_words) * c_bytes;
  assign wcnt_sum    = {1'b0, wcnt_q} + WSW'(burst_words);
  // ">=" rather than "==" keeps the wrap robust if a flushed partial burst
  // has left the counter off the BURST grid.
  assign frame_end   = (wcnt_sum >= c_frame);

  assign cmd_addr_o   = addr_q;
  assign cmd_len_o    = len_q;
  assign frame_done_o = done_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    wcnt_d    = wcnt_q;
    done_d    = 1'b0;
    cmd_val_o = 1'b0;
    wr_val_o  = 1'b0;
    wr_last_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A full burst is only started once all its words are buffered, so
        // the data phase never starves mid-burst.
        if (count_q >= c_burst) begin
          state_d = S_CMD;
          len_d   = c_len_full;
        end else if (flush_req && (count_q != '0)) begin
          state_d = S_CMD;
          len_d   = 8'(count_q - CW'(1));
        end
      end

      S_CMD: begin
        cmd_val_o = 1'b1;
        if (cmd_rdy_i) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end

      S_DATA: begin
        wr_val_o  = (count_q != '0);
        wr_last_o = wr_val_o && (beat_q == len_q);
        if (wr_val_o && wr_rdy_i) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) begin
            state_d = S_IDLE;
            if (frame_end) begin
              wcnt_d = '0;
              addr_d = BASE;
              done_d = 1'b1;
            end else begin
              wcnt_d = WCW'(wcnt_sum);
              addr_d = addr_q + addr_inc;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      len_q   <= c_len_full;
      beat_q  <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire
